// File: rtl/prio_intr_controller.sv
// Fixed-priority interrupt controller: per-source edge/level capture into pending
// bits, lowest-index enabled source dispatched and held until acknowledged.
module prio_intr_controller #(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned VEC_W = 3
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic [N_SRC-1:0] I_intr_rq,
    input  logic [N_SRC-1:0] I_intr_en,
    input  logic [N_SRC-1:0] I_edge_mode,
    input  logic             I_intr_ack,
    output logic             O_intr,
    output logic [VEC_W-1:0] O_intr_vector,
    output logic [N_SRC-1:0] O_pending
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             intr_q, intr_d;
    logic [VEC_W-1:0] vector_q, vector_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] rq_prev_q;

    logic [N_SRC-1:0] set_v;
    logic [N_SRC-1:0] clr_v;
    logic [N_SRC-1:0] cand;
    logic [VEC_W-1:0] winner;
    logic             found;

    // Lowest enabled pending index; only the first hit is taken.
    always_comb begin
        cand   = pending_q & I_intr_en;
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (cand[i] && !found) begin
                winner = VEC_W'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        set_v = I_intr_rq & (~I_edge_mode | ~rq_prev_q);
        clr_v = '0;
        if (state_q == WAIT_ACK && I_intr_ack) begin
            clr_v = {{(N_SRC-1){1'b0}}, 1'b1} << vector_q;
        end
        // A fresh request on the acknowledged source overrides its clear.
        pending_d = (pending_q & ~clr_v) | set_v;
    end

    always_comb begin
        state_d  = state_q;
        intr_d   = intr_q;
        vector_d = vector_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = WAIT_ACK;
                    intr_d   = 1'b1;
                    vector_d = winner;
                end
            end
            WAIT_ACK: begin
                if (I_intr_ack) begin
                    state_d = IDLE;
                    intr_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                intr_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q   <= IDLE;
            intr_q    <= 1'b0;
            vector_q  <= '0;
            pending_q <= '0;
            rq_prev_q <= '0;
        end else begin
            state_q   <= state_d;
            intr_q    <= intr_d;
            vector_q  <= vector_d;
            pending_q <= pending_d;
            rq_prev_q <= I_intr_rq;
        end
    end

    assign O_intr        = intr_q;
    assign O_intr_vector = vector_q;
    assign O_pending     = pending_q;

endmodule
